// File: rtl/reg_history.sv
// DEPTH-stage shift history with clear, parallel load and saturating occupancy count.
// Define REG_HISTORY_SUM_EN to add a registered stage0+stage1 sum output.
module reg_history #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   ld,
  input  logic [WIDTH-1:0]       din,
  input  logic [DEPTH*WIDTH-1:0] ld_bus,
  output logic [DEPTH*WIDTH-1:0] taps,
  output logic [CW-1:0]          count,
  output logic                   full
`ifdef REG_HISTORY_SUM_EN
  , output logic [WIDTH:0]       sum
`endif
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] stage, stage_nxt;
  logic [CW-1:0]               count_nxt;

  // Next-state for all stages, shared by the stage registers and the sum adder.
  always_comb begin
    stage_nxt = stage;
    count_nxt = count;
    if (clr) begin
      stage_nxt = '0;
      count_nxt = '0;
    end else if (ld) begin
      for (int k = 0; k < DEPTH; k++)
        stage_nxt[k] = ld_bus[k*WIDTH +: WIDTH];
      count_nxt = DEPTH_C;
    end else if (en) begin
      stage_nxt[0] = din;
      for (int k = 1; k < DEPTH; k++)
        stage_nxt[k] = stage[k-1];
      if (count < DEPTH_C)
        count_nxt = count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage <= '0;
      count <= '0;
    end else begin
      stage <= stage_nxt;
      count <= count_nxt;
    end
  end

`ifdef REG_HISTORY_SUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      sum <= '0;
    else
      sum <= {1'b0, stage_nxt[0]} + {1'b0, stage_nxt[1]};
  end
`endif

  assign taps = stage;
  assign full = (count == DEPTH_C);

endmodule
